// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative multiply/divide unit that owns the HI/LO registers.
// Operands come straight from the register-file read ports. A shift-add
// multiply or a restoring divide runs for WIDTH cycles on operand magnitudes.
// Signs are reapplied in a final fix-up cycle. MTHI/MTLO may write HI/LO in
// any state, but a finishing operation takes priority over them.
module muldiv_hilo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREP,
      ST_RUN,
      ST_FIX
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       count_q, count_d;
   logic                done_q, done_d;
   logic [1:0]          op_q, op_d;
   logic [WIDTH-1:0]    a_q, a_d;
   logic [WIDTH-1:0]    b_q, b_d;
   logic [WIDTH-1:0]    opnd_q, opnd_d;
   logic [2*WIDTH-1:0]  acc_q, acc_d;
   logic                neg_lo_q, neg_lo_d;
   logic                neg_hi_q, neg_hi_d;
   logic [WIDTH-1:0]    hi_q, hi_d;
   logic [WIDTH-1:0]    lo_q, lo_d;

   // op bit 1 selects divide, op bit 0 clear means a signed operation
   logic                is_div;
   logic                is_signed;
   logic                a_neg;
   logic                b_neg;
   logic [WIDTH-1:0]    a_mag;
   logic [WIDTH-1:0]    b_mag;
   logic [WIDTH-1:0]    mul_addend;
   logic [WIDTH:0]      mul_sum;
   logic [WIDTH:0]      div_trial;
   logic                div_ok;
   logic [2*WIDTH-1:0]  prod_fixed;
   logic [WIDTH-1:0]    quot_fixed;
   logic [WIDTH-1:0]    rem_fixed;
   logic [WIDTH-1:0]    fix_hi;
   logic [WIDTH-1:0]    fix_lo;

   assign is_div    = op_q[1];
   assign is_signed = ~op_q[0];
   assign a_neg     = is_signed & a_q[WIDTH-1];
   assign b_neg     = is_signed & b_q[WIDTH-1];
   assign a_mag     = a_neg ? -a_q : a_q;
   assign b_mag     = b_neg ? -b_q : b_q;

   // Multiply step: conditionally add the multiplicand into the upper half,
   // keeping the carry so the following right shift does not lose it.
   always_comb begin
      mul_addend = '0;
      if (acc_q[0]) begin
         mul_addend = opnd_q;
      end
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
   end

   // Divide step: trial-subtract the divisor from the remainder shifted left
   // by one. A clear top bit means the subtraction fits and the quotient bit is 1.
   always_comb begin
      div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
      div_ok    = ~div_trial[WIDTH];
   end

   // Fix-up values: reapply the recorded signs. A zero divisor overrides
   // everything with the architectural HI=dividend, LO=all-ones result.
   always_comb begin
      prod_fixed = neg_lo_q ? -acc_q : acc_q;
      quot_fixed = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fixed  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      fix_hi     = prod_fixed[2*WIDTH-1:WIDTH];
      fix_lo     = prod_fixed[WIDTH-1:0];
      if (is_div) begin
         if (b_q == '0) begin
            fix_hi = a_q;
            fix_lo = '1;
         end else begin
            fix_hi = rem_fixed;
            fix_lo = quot_fixed;
         end
      end
   end

   // Control FSM next state: IDLE -> PREP -> RUN (WIDTH cycles) -> FIX -> IDLE
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_PREP;
            end
         end
         ST_PREP: begin
            count_d = '0;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            count_d = count_q + CW'(1);
            if (count_q == LAST_COUNT) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Datapath next state: latch operands, set up magnitudes and signs, iterate
   always_comb begin
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               op_d = op_i;
               a_d  = a_i;
               b_d  = b_i;
            end
         end
         ST_PREP: begin
            neg_lo_d = a_neg ^ b_neg;
            if (is_div) begin
               acc_d    = {{WIDTH{1'b0}}, a_mag};
               opnd_d   = b_mag;
               neg_hi_d = a_neg;
            end else begin
               acc_d    = {{WIDTH{1'b0}}, b_mag};
               opnd_d   = a_mag;
               neg_hi_d = a_neg ^ b_neg;
            end
         end
         ST_RUN: begin
            if (is_div) begin
               if (div_ok) begin
                  acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
               end
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
         end
         default: begin
         end
      endcase
   end

   // HI/LO next state: MTHI/MTLO writes, overridden by a completing operation
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (hi_we_i) begin
         hi_d = wdata_i;
      end
      if (lo_we_i) begin
         lo_d = wdata_i;
      end
      if (state_q == ST_FIX) begin
         hi_d = fix_hi;
         lo_d = fix_lo;
      end
   end

   // State register; reset drops any in-flight operation and clears HI/LO
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         done_q   <= 1'b0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         done_q   <= done_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy_o = (state_q != ST_IDLE);
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Iterative multiply/divide unit with the architectural HI/LO registers.
- Sits directly downstream of the register file: its operands are the two register-file read ports (rs, rt).
- Serves MULT/MULTU/DIV/DIVU plus MTHI/MTLO; HI/LO are returned to writeback for MFHI/MFLO.
- Multi-cycle with a busy/done handshake, so the control FSM stalls MFHI/MFLO while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset_i  input  1  asynchronous active-high reset
- start_i  input  1  start request; sampled only in IDLE
- op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i
- a_i  input  32  rs operand (register-file read port 1)
- b_i  input  32  rt operand (register-file read port 2)
- hi_we_i  input  1  MTHI write enable
- lo_we_i  input  1  MTLO write enable
- wdata_i  input  32  MTHI/MTLO data
- busy_o  output  1  operation in flight
- done_o  output  1  one-cycle pulse when HI/LO receive a result
- hi_o  output  32  HI register
- lo_o  output  32  LO register

Behaviour:
- Reset (async, any state): state=IDLE; hi_o=lo_o=0; busy_o=0; done_o=0; counter and datapath cleared. Any in-flight operation is discarded.
- States:
  - IDLE -> PREP on start_i=1. Latch op, a_i, b_i; busy_o=1 from the next cycle.
  - PREP (1 cycle): for signed ops, take magnitudes of the operands. Record result signs:
    - product sign = a^b
    - quotient sign = a^b
    - remainder sign = a
    - Clear the 64-bit accumulator; count=0. Go to RUN.
  - RUN (exactly 32 cycles, count 0..31):
    - Multiply: shift-add, one multiplier bit per cycle, LSB first.
    - Divide: restoring, one quotient bit per cycle, MSB first.
    - At count=31 go to FIX.
  - FIX (1 cycle): apply two's-complement sign fixes, write HI/LO, pulse done_o=1, clear busy_o, return to IDLE.
- Latency: start sampled at edge E0; HI/LO updated and done_o high after edge E34; busy_o high in cycles E0..E34.
- Results:
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (b=0): same 34-cycle latency; HI = a_i (as latched), LO = 32'hFFFF_FFFF, for DIV and DIVU.
- Signed overflow: DIV 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0. No exception.
- start_i while busy_o=1: ignored; no queueing.
- MTHI/MTLO:
  - Write takes effect at the next edge, in any state.
  - hi_we_i and lo_we_i together write both registers with wdata_i.
  - If asserted in the same cycle as FIX, the FIX result wins for both registers.
  - MTHI/MTLO during RUN does not affect the in-flight computation.
- hi_o/lo_o are pure register outputs with no bypass; they hold between writes.
- done_o is never high for two consecutive cycles.

Test Plan:
- Reset mid-RUN (count≈10), then deassert -> hi_o=lo_o=0, busy_o=0, done_o never pulses; a following MULTU 3×5 gives HI=0, LO=15.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF -> after 34 cycles HI=0xFFFF_FFFE, LO=0x0000_0001, done_o one pulse. MULT -1×1 -> HI=LO=0xFFFF_FFFF.
- DIV -7/2 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1). DIVU 7/2 -> LO=3, HI=1. DIV 0x8000_0000/-1 -> LO=0x8000_0000, HI=0.
- DIVU 0x1234/0 -> HI=0x1234, LO=0xFFFF_FFFF, latency 34.
- start_i pulsed again at cycle 5 with different operands -> ignored, first result only. MTLO 0xAA at cycle 10 -> lo_o=0xAA until FIX overwrites it. MTHI in the FIX cycle -> FIX result retained.
- IDLE: hi_we_i=lo_we_i=1, wdata_i=0x5A5A_5A5A -> both registers read 0x5A5A_5A5A; busy_o and done_o stay 0.
